// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order writeback stage
//   (priority writer) and a multi-cycle unit (load/divide) whose results wait in a
//   DEPTH-entry FIFO behind a valid/ready handshake. The write port is registered.
//
// Optional feature: define WB_ARB_STARVE_GUARD_EN to enable the starvation guard. A
//   FIFO head that has waited MAX_WAIT cycles then stalls writeback for one cycle and
//   takes the port. With the macro undefined wb_stall is tied low.
//
// Ports
//   clk1       in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   wb_valid   in   writeback result present (rd==0 counts as no request)
//   wb_rd      in   writeback destination register
//   wb_data    in   writeback result
//   wb_stall   out  writeback must hold its inputs this cycle
//   mc_valid   in   multi-cycle result offered
//   mc_rd      in   multi-cycle destination register
//   mc_data    in   multi-cycle result
//   mc_ready   out  FIFO can accept (push on mc_valid && mc_ready)
//   rf_we      out  register-file write enable (registered)
//   rf_rd      out  register-file write address (registered)
//   rf_wd      out  register-file write data (registered)
//   pend_cnt   out  FIFO occupancy
module wb_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_rd,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       wb_stall,
  input  logic                       mc_valid,
  input  logic [4:0]                 mc_rd,
  input  logic [XLEN-1:0]            mc_data,
  output logic                       mc_ready,
  output logic                       rf_we,
  output logic [4:0]                 rf_rd,
  output logic [XLEN-1:0]            rf_wd,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("DEPTH must be a power of 2 and at least 2");
  end
  if (MAX_WAIT < 1) begin : g_wait_check
    $error("MAX_WAIT must be at least 1");
  end

  logic [4:0]      fifo_rd_q   [DEPTH];
  logic [XLEN-1:0] fifo_data_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  logic fifo_empty;
  logic wb_req;
  logic grant_wb;
  logic push;
  logic pop;

  // Handshake and grant decode; everything here depends on registered state only
  // (plus current-cycle requests), so there is no combinational path through wb_stall.
  always_comb begin
    fifo_empty = (cnt_q == '0);
    mc_ready   = (cnt_q != CntW'(DEPTH));
    wb_req     = wb_valid && (wb_rd != 5'd0);
    grant_wb   = wb_req && !wb_stall;
    pop        = !grant_wb && !fifo_empty;
    push       = mc_valid && mc_ready;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Write-port next state. A popped x0 entry still consumes its slot but never writes.
  always_comb begin
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (grant_wb) begin
      rf_we_d = 1'b1;
      rf_rd_d = wb_rd;
      rf_wd_d = wb_data;
    end else if (pop) begin
      rf_we_d = (fifo_rd_q[rd_ptr_q] != 5'd0);
      rf_rd_d = fifo_rd_q[rd_ptr_q];
      rf_wd_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk1) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= mc_rd;
      fifo_data_q[wr_ptr_q] <= mc_data;
    end
  end

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int unsigned WaitW = $clog2(MAX_WAIT+1);

  logic [WaitW-1:0] wait_q, wait_d;

  // Once the limit is reached the next cycle is a forced pop, which clears the count.
  always_comb begin
    wait_d = wait_q;
    if (fifo_empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wb_stall = (wait_q == WaitW'(MAX_WAIT));
`else
  assign wb_stall = 1'b0;
`endif

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wd    = rf_wd_q;
  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (XLEN=32, DEPTH=4, MAX_WAIT=8).
module tb_wb_port_arbiter;

  logic        clk1;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [2:0]  pend_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  wb_port_arbiter #(
    .XLEN     (32),
    .DEPTH    (4),
    .MAX_WAIT (8)
  ) u_dut (
    .clk1     (clk1),
    .rst      (rst),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_stall (wb_stall),
    .mc_valid (mc_valid),
    .mc_rd    (mc_rd),
    .mc_data  (mc_data),
    .mc_ready (mc_ready),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_wd    (rf_wd),
    .pend_cnt (pend_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Advance one rising edge, then settle 1 time unit so registered outputs are stable.
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    mc_valid = 1'b0; mc_rd = '0; mc_data = '0;
    #3;
    vec_cnt++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0) begin
      $display("FAIL reset_port: we=%b rd=%0d wd=%h required 0/0/0", rf_we, rf_rd, rf_wd);
      err_cnt++;
    end
    vec_cnt++;
    if (pend_cnt !== 3'd0 || wb_stall !== 1'b0 || mc_ready !== 1'b1) begin
      $display("FAIL reset_state: pend=%0d stall=%b ready=%b required 0/0/1",
               pend_cnt, wb_stall, mc_ready);
      err_cnt++;
    end
    @(negedge clk1);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_wb_write();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
      $display("FAIL wb_write: we=%b rd=%0d wd=%h required 1/5/deadbeef", rf_we, rf_rd, rf_wd);
      err_cnt++;
    end
    wb_rd = 5'd0; wb_data = 32'h1234;
    tick();
    vec_cnt++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
      $display("FAIL wb_x0: we=%b rd=%0d wd=%h required 0/5/deadbeef (held)", rf_we, rf_rd, rf_wd);
      err_cnt++;
    end
    wb_valid = 1'b0;
    tick();
  endtask

  task automatic test_mc_write();
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h11;
    tick();
    mc_valid = 1'b0;
    vec_cnt++;
    if (rf_we !== 1'b0 || pend_cnt !== 3'd1) begin
      $display("FAIL mc_t1: we=%b pend=%0d required 0/1 (no bypass)", rf_we, pend_cnt);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h11 || pend_cnt !== 3'd0) begin
      $display("FAIL mc_t2: we=%b rd=%0d wd=%h pend=%0d required 1/7/11/0",
               rf_we, rf_rd, rf_wd, pend_cnt);
      err_cnt++;
    end
    tick();
  endtask

  task automatic test_fill_drain();
    for (int r = 0; r < 3; r++) begin
      wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h900 + r;
      for (int i = 1; i <= 4; i++) begin
        mc_valid = 1'b1; mc_rd = 5'(i); mc_data = 32'h100 * (r + 1) + i;
        tick();
        vec_cnt++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin
          $display("FAIL fill_wb r%0d i%0d: we=%b rd=%0d required 1/9", r, i, rf_we, rf_rd);
          err_cnt++;
        end
      end
      mc_valid = 1'b0;
      vec_cnt++;
      if (pend_cnt !== 3'd4 || mc_ready !== 1'b0) begin
        $display("FAIL full r%0d: pend=%0d ready=%b required 4/0", r, pend_cnt, mc_ready);
        err_cnt++;
      end
      wb_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
        tick();
        vec_cnt++;
        if (rf_we !== 1'b1 || rf_rd !== 5'(i) || rf_wd !== 32'h100 * (r + 1) + i) begin
          $display("FAIL drain r%0d i%0d: we=%b rd=%0d wd=%h required 1/%0d/%h",
                   r, i, rf_we, rf_rd, rf_wd, i, 32'h100 * (r + 1) + i);
          err_cnt++;
        end
      end
      tick();
      vec_cnt++;
      if (rf_we !== 1'b0 || pend_cnt !== 3'd0) begin
        $display("FAIL drained r%0d: we=%b pend=%0d required 0/0", r, rf_we, pend_cnt);
        err_cnt++;
      end
    end
  endtask

  task automatic test_simul_push_pop();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9;
    mc_valid = 1'b1; mc_rd = 5'd10; mc_data = 32'hA0;
    tick();
    mc_rd = 5'd11; mc_data = 32'hB0;
    tick();
    // pend_cnt is 2 here; pop A while pushing C.
    wb_valid = 1'b0;
    mc_rd = 5'd12; mc_data = 32'hC0;
    tick();
    mc_valid = 1'b0;
    vec_cnt++;
    if (pend_cnt !== 3'd2 || rf_we !== 1'b1 || rf_rd !== 5'd10 || rf_wd !== 32'hA0) begin
      $display("FAIL pushpop: pend=%0d we=%b rd=%0d wd=%h required 2/1/10/a0",
               pend_cnt, rf_we, rf_rd, rf_wd);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (rf_rd !== 5'd11 || rf_wd !== 32'hB0 || pend_cnt !== 3'd1) begin
      $display("FAIL pushpop_b: rd=%0d wd=%h pend=%0d required 11/b0/1", rf_rd, rf_wd, pend_cnt);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (rf_rd !== 5'd12 || rf_wd !== 32'hC0 || pend_cnt !== 3'd0) begin
      $display("FAIL pushpop_c: rd=%0d wd=%h pend=%0d required 12/c0/0", rf_rd, rf_wd, pend_cnt);
      err_cnt++;
    end
    // Fill, then keep offering while full; also offer during the first pop.
    wb_valid = 1'b1;
    for (int i = 13; i <= 16; i++) begin
      mc_valid = 1'b1; mc_rd = 5'(i); mc_data = 32'(i);
      tick();
    end
    mc_rd = 5'd20; mc_data = 32'h20;
    tick();
    tick();
    vec_cnt++;
    if (pend_cnt !== 3'd4 || mc_ready !== 1'b0) begin
      $display("FAIL full_refuse: pend=%0d ready=%b required 4/0", pend_cnt, mc_ready);
      err_cnt++;
    end
    wb_valid = 1'b0;
    tick();
    mc_valid = 1'b0;
    vec_cnt++;
    if (pend_cnt !== 3'd3 || rf_rd !== 5'd13) begin
      $display("FAIL full_pop_refuse: pend=%0d rd=%0d required 3/13", pend_cnt, rf_rd);
      err_cnt++;
    end
    for (int i = 14; i <= 16; i++) begin
      tick();
      vec_cnt++;
      if (rf_we !== 1'b1 || rf_rd !== 5'(i)) begin
        $display("FAIL full_drain %0d: we=%b rd=%0d required 1/%0d", i, rf_we, rf_rd, i);
        err_cnt++;
      end
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b0 || pend_cnt !== 3'd0) begin
      $display("FAIL full_empty: we=%b pend=%0d required 0/0", rf_we, pend_cnt);
      err_cnt++;
    end
  endtask

  task automatic test_mc_x0();
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h77;
    tick();
    mc_rd = 5'd3; mc_data = 32'h33;
    tick();
    mc_valid = 1'b0;
    vec_cnt++;
    if (rf_we !== 1'b0 || pend_cnt !== 3'd1) begin
      $display("FAIL mc_x0: we=%b pend=%0d required 0/1", rf_we, pend_cnt);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wd !== 32'h33 || pend_cnt !== 3'd0) begin
      $display("FAIL mc_after_x0: we=%b rd=%0d wd=%h pend=%0d required 1/3/33/0",
               rf_we, rf_rd, rf_wd, pend_cnt);
      err_cnt++;
    end
    tick();
  endtask

  task automatic test_starve();
    wb_valid = 1'b1; wb_rd = 5'd21; wb_data = 32'hAA;
    mc_valid = 1'b1; mc_rd = 5'd22; mc_data = 32'h55;
    tick();
    mc_valid = 1'b0;
`ifdef WB_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      vec_cnt++;
      if (wb_stall !== (k == 8) || rf_rd !== 5'd21) begin
        $display("FAIL starve k%0d: stall=%b rd=%0d required %0d/21", k, wb_stall, rf_rd, k == 8);
        err_cnt++;
      end
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd22 || rf_wd !== 32'h55 || wb_stall !== 1'b0) begin
      $display("FAIL starve_grant: we=%b rd=%0d wd=%h stall=%b required 1/22/55/0",
               rf_we, rf_rd, rf_wd, wb_stall);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd21 || pend_cnt !== 3'd0) begin
      $display("FAIL starve_wb_after: we=%b rd=%0d pend=%0d required 1/21/0",
               rf_we, rf_rd, pend_cnt);
      err_cnt++;
    end
    wb_valid = 1'b0;
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      vec_cnt++;
      if (wb_stall !== 1'b0 || rf_rd !== 5'd21 || pend_cnt !== 3'd1) begin
        $display("FAIL nostarve k%0d: stall=%b rd=%0d pend=%0d required 0/21/1",
                 k, wb_stall, rf_rd, pend_cnt);
        err_cnt++;
      end
    end
    wb_valid = 1'b0;
    tick();
    vec_cnt++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd22 || rf_wd !== 32'h55) begin
      $display("FAIL nostarve_drain: we=%b rd=%0d wd=%h required 1/22/55", rf_we, rf_rd, rf_wd);
      err_cnt++;
    end
`endif
    tick();
  endtask

  task automatic test_async_reset();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h5;
    for (int i = 1; i <= 3; i++) begin
      mc_valid = 1'b1; mc_rd = 5'(i); mc_data = 32'(i);
      tick();
    end
    mc_valid = 1'b0;
    vec_cnt++;
    if (pend_cnt !== 3'd3 || rf_we !== 1'b1) begin
      $display("FAIL pre_reset: pend=%0d we=%b required 3/1", pend_cnt, rf_we);
      err_cnt++;
    end
    #2;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== 32'd0 || pend_cnt !== 3'd0) begin
      $display("FAIL async_reset: we=%b rd=%0d wd=%h pend=%0d required 0/0/0/0",
               rf_we, rf_rd, rf_wd, pend_cnt);
      err_cnt++;
    end
    wb_valid = 1'b0;
    @(negedge clk1);
    rst = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (pend_cnt !== 3'd0 || mc_ready !== 1'b1 || rf_we !== 1'b0) begin
      $display("FAIL post_reset: pend=%0d ready=%b we=%b required 0/1/0",
               pend_cnt, mc_ready, rf_we);
      err_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_mc_write();
    test_fill_drain();
    test_simul_push_pop();
    test_mc_x0();
    test_starve();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
